// File: rtl/or_gate_sync.sv
// Two-input bitwise OR with a zero-latency output plus registered status:
// the OR value, its reduction, a rising-edge pulse and a saturating activity count.
module or_gate_sync #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     z,
  output logic [WIDTH-1:0]     z_q,
  output logic                 any_q,
  output logic                 rise_q,
  output logic [CNT_WIDTH-1:0] hi_cnt
);

  logic [WIDTH-1:0]     or_val;
  logic                 any_d;

  logic [WIDTH-1:0]     zr_q,   zr_d;
  logic                 any_r_q;
  logic                 rise_r_q, rise_d;
  logic [CNT_WIDTH-1:0] cnt_q,  cnt_d;

  always_comb begin
    or_val = a | b;
    any_d  = |or_val;
    zr_d   = or_val;
    rise_d = any_d & ~any_r_q;
    cnt_d  = cnt_q;
    // Count on the registered activity flag; hold once all ones is reached.
    if (any_r_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zr_q     <= '0;
      any_r_q  <= 1'b0;
      rise_r_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      zr_q     <= zr_d;
      any_r_q  <= any_d;
      rise_r_q <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign z      = or_val;
  assign z_q    = zr_q;
  assign any_q  = any_r_q;
  assign rise_q = rise_r_q;
  assign hi_cnt = cnt_q;

endmodule

// File: tb/tb_or_gate_sync.sv
// Self-checking bench for or_gate_sync: directed steps plus randomized traffic
// compared against a cycle-level reference model of the OR/status rules.
module tb_or_gate_sync;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          clk_en;
  logic          rst;
  logic [W-1:0]  a, b;
  logic [W-1:0]  z, z_q;
  logic          any_q, rise_q;
  logic [CW-1:0] hi_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state
  logic [W-1:0] m_zq;
  logic         m_any, m_rise;
  int unsigned  m_cnt;

  or_gate_sync #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .z      (z),
    .z_q    (z_q),
    .any_q  (any_q),
    .rise_q (rise_q),
    .hi_cnt (hi_cnt)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_regs();
    chk("z_q",    32'(z_q),    32'(m_zq));
    chk("any_q",  32'(any_q),  32'(m_any));
    chk("rise_q", 32'(rise_q), 32'(m_rise));
    chk("hi_cnt", 32'(hi_cnt), m_cnt);
  endtask

  // One clock: apply inputs, check z combinationally, advance model at the edge,
  // then check registered outputs on the falling edge.
  task automatic tick(input logic [W-1:0] na, input logic [W-1:0] nb, input logic nr);
    logic         hit;
    a = na; b = nb; rst = nr;
    #1;
    chk("z", 32'(z), 32'(na | nb));
    @(posedge clk);
    hit = ((na | nb) != 0);
    if (nr) begin
      m_zq = '0; m_any = 1'b0; m_rise = 1'b0; m_cnt = 0;
    end else begin
      if (m_any && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      m_rise = hit && !m_any;
      m_any  = hit;
      m_zq   = na | nb;
    end
    @(negedge clk);
    chk_regs();
  endtask

  initial begin
    clk = 1'b0; clk_en = 1'b1; rst = 1'b1; a = '0; b = '0;
    m_zq = '0; m_any = 1'b0; m_rise = 1'b0; m_cnt = 0;

    // Reset state
    tick('0, '0, 1'b1);
    chk("rst_hi_cnt", 32'(hi_cnt), 32'd0);

    // Step 1: all zero
    tick('0, '0, 1'b0);

    // Step 2: single pulse on rising activity
    tick('0, 4'b0001, 1'b0);
    chk("rise_pulse", 32'(rise_q), 32'd1);
    tick('0, 4'b0001, 1'b0);
    chk("rise_once", 32'(rise_q), 32'd0);

    // Step 3: activity stays high, no further pulses
    tick(4'b1000, '0, 1'b0);
    tick(4'b1010, 4'b0101, 1'b0);
    chk("rise_held", 32'(rise_q), 32'd0);

    // X propagation: 1 | X = 1
    a = 4'bx1x0; b = 4'b1010; #1;
    chk("z_x_or_1", 32'(z[3]), 32'd1);
    chk("z_bit2", 32'(z[2]), 32'd1);

    // Step 4: clock idle, z follows inputs, registers hold
    tick('0, '0, 1'b0);
    clk_en = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      a = (i[1]) ? 4'b0110 : '0;
      b = (i[0]) ? 4'b1001 : '0;
      #10;
      chk("z_idle", 32'(z), 32'(a | b));
    end
    chk_regs();
    #2 clk_en = 1'b1;

    // Step 5: saturation with constant activity
    for (int unsigned i = 0; i < 300; i++) tick(4'b0001, '0, 1'b0);
    chk("sat_255", 32'(hi_cnt), 32'd255);
    tick(4'b1111, '0, 1'b0);
    chk("no_wrap", 32'(hi_cnt), 32'd255);

    // Step 6: reset mid-run with activity present
    tick(4'b0001, '0, 1'b1);
    chk("mid_rst_cnt", 32'(hi_cnt), 32'd0);
    chk("mid_rst_any", 32'(any_q), 32'd0);
    tick(4'b0001, '0, 1'b0);
    chk("post_rst_rise", 32'(rise_q), 32'd1);
    chk("post_rst_cnt0", 32'(hi_cnt), 32'd0);
    tick(4'b0001, '0, 1'b0);
    chk("post_rst_cnt1", 32'(hi_cnt), 32'd1);

    // Randomized traffic with sparse activity and occasional reset
    for (int unsigned i = 0; i < 250; i++) begin
      logic [W-1:0] ra, rb;
      logic         rr;
      ra = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      rb = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      rr = ($urandom_range(0, 19) == 0);
      tick(ra, rb, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
